// File: rtl/mode_timer_pkg.sv
// mode_timer_pkg: mode encodings, FSM state type and mode decode shared by mode_timer.
package mode_timer_pkg;

    typedef enum logic [1:0] {
        ONESHOT  = 2'b00,
        RETRIG   = 2'b01,
        PERIODIC = 2'b10
    } mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // The reserved encoding 2'b11 behaves as ONESHOT.
    function automatic mode_e decode_mode(input logic [1:0] raw);
        case (raw)
            2'b01:   return RETRIG;
            2'b10:   return PERIODIC;
            default: return ONESHOT;
        endcase
    endfunction

endpackage

// File: rtl/mode_timer_prescaler.sv
// timer_prescaler: emits a one-cycle tick every presc+1 cycles; clr restarts the period.
module timer_prescaler #(
    parameter int unsigned PS_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic [PS_W-1:0] presc,
    output logic            tick
);

    logic [PS_W-1:0] cnt_q;
    logic [PS_W-1:0] cnt_d;

    assign tick = (cnt_q == presc);

    // Next divider value: restart on clr or after a tick, otherwise count up.
    always_comb begin
        if (clr || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + PS_W'(1);
        end
    end

    // Divider register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mode_timer.sv
// mode_timer: one-shot / retriggerable / periodic pulse timer.
// Optional feature macro: TIMER_PRESCALE_EN adds input presc and a tick
// divider (timer_prescaler); without it the timer ticks every cycle.
module mode_timer
    import mode_timer_pkg::*;
#(
    parameter int unsigned N    = 5,
    parameter int unsigned PS_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            trig,
    input  logic [N-1:0]    load,
    input  logic [1:0]      mode,
    input  logic            enable,
    output logic            out_pulse,
    output logic            busy,
    output logic            done,
    output logic [N-1:0]    count
`ifdef TIMER_PRESCALE_EN
    ,
    input  logic [PS_W-1:0] presc
`endif
);

    state_e       state_q;
    mode_e        mode_q;
    logic [N-1:0] count_q;
    logic         out_q;
    logic         done_q;
    logic         trig_q;
    // Set once trig has been seen low after reset; a level already high at
    // reset release must fall and rise again before it counts as an edge.
    logic         armed_q;

    logic tick;
    logic trig_edge;
    logic load_ok;
    logic start;
    logic retrig;
    logic expire;
    logic per_reload;

`ifdef TIMER_PRESCALE_EN
    logic presc_clr;

    // Every start or reload restarts the divider so the first tick lands presc+1 cycles later.
    assign presc_clr = start | retrig | per_reload;

    timer_prescaler #(
        .PS_W (PS_W)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .clr   (presc_clr),
        .presc (presc),
        .tick  (tick)
    );
`else
    // PS_W only sizes the divider; without it every cycle is a tick.
    assign tick = (PS_W > 0);
`endif

    // Decode the events that drive the FSM this cycle.
    // NOTE: every signal gets a value on every path, so no latch is inferred.
    always_comb begin
        trig_edge  = trig & ~trig_q & armed_q;
        load_ok    = (load != '0);
        start      = (state_q == IDLE) & enable & trig_edge & load_ok;
        retrig     = (state_q == RUN) & enable & (mode_q == RETRIG) & trig_edge & load_ok;
        expire     = (state_q == RUN) & enable & tick & (count_q == N'(1));
        per_reload = expire & (mode_q == PERIODIC) & trig & load_ok;
    end

    // Timer FSM with registered outputs; retrigger has priority over expiry.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge value of every other register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= ONESHOT;
            count_q <= '0;
            out_q   <= 1'b0;
            done_q  <= 1'b0;
            trig_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            trig_q  <= trig;
            armed_q <= armed_q | ~trig;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        count_q <= load;
                        out_q   <= 1'b1;
                        mode_q  <= decode_mode(mode);
                    end
                end
                RUN: begin
                    if (retrig) begin
                        count_q <= load;
                    end else if (expire) begin
                        done_q <= 1'b1;
                        if (per_reload) begin
                            count_q <= load;
                            out_q   <= ~out_q;
                        end else begin
                            state_q <= IDLE;
                            count_q <= '0;
                            out_q   <= 1'b0;
                        end
                    end else if (enable && tick) begin
                        count_q <= count_q - N'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_pulse = out_q;
    assign busy      = (state_q == RUN);
    assign done      = done_q;
    assign count     = count_q;

endmodule

// File: tb/tb_mode_timer.sv
// tb_mode_timer: directed scenarios with literal expectations plus a randomized
// run, all compared every cycle against a behavioural model of the timer.
module tb_mode_timer;

    localparam int N = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         trig;
    logic [N-1:0] load;
    logic [1:0]   mode;
    logic         enable;
    logic         out_pulse;
    logic         busy;
    logic         done;
    logic [N-1:0] count;
`ifdef TIMER_PRESCALE_EN
    logic [3:0]   presc;
`endif

    int checks   = 0;
    int failures = 0;
    bit check_en = 1'b0;

    int hi_total   = 0;
    int done_total = 0;

    always #5 clk = ~clk;

    mode_timer #(
        .N    (N),
        .PS_W (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .trig      (trig),
        .load      (load),
        .mode      (mode),
        .enable    (enable),
        .out_pulse (out_pulse),
        .busy      (busy),
        .done      (done),
        .count     (count)
`ifdef TIMER_PRESCALE_EN
        ,
        .presc     (presc)
`endif
    );

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Timer seen as: an active run with some ticks left, an output level, a
    // run kind, and a one-cycle expiry flag.
    bit m_trig_prev, m_armed, m_active, m_level, m_done;
    int m_left, m_kind, m_pdiv;

    always @(posedge clk or posedge rst) begin : model
        bit rise;
        bit tick_now;
        bit restart;
        if (rst) begin
            m_trig_prev = 0; m_armed = 0; m_active = 0; m_level = 0;
            m_done = 0; m_left = 0; m_kind = 0; m_pdiv = 0;
        end else begin
            rise    = trig && !m_trig_prev && m_armed;
            restart = 0;
`ifdef TIMER_PRESCALE_EN
            tick_now = (m_pdiv == int'(presc));
`else
            tick_now = 1'b1;
`endif
            m_pdiv = tick_now ? 0 : (m_pdiv + 1) % 16;
            m_done = 0;
            if (!m_active) begin
                if (enable && rise && load != 0) begin
                    m_active = 1; m_left = int'(load); m_level = 1; restart = 1;
                    m_kind = (mode == 2'd1) ? 1 : (mode == 2'd2) ? 2 : 0;
                end
            end else if (enable) begin
                if (m_kind == 1 && rise && load != 0) begin
                    m_left = int'(load); restart = 1;
                end else if (tick_now) begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_done = 1;
                        if (m_kind == 2 && trig && load != 0) begin
                            m_left = int'(load); m_level = !m_level; restart = 1;
                        end else begin
                            m_active = 0; m_level = 0;
                        end
                    end
                end
            end
            if (restart) m_pdiv = 0;
            m_trig_prev = trig;
            m_armed     = m_armed | !trig;
        end
    end

    // Single compare process: DUT against model, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            check("cmp_count", int'(count), m_left);
            check("cmp_out_pulse", int'(out_pulse), int'(m_level));
            check("cmp_busy", int'(busy), int'(m_active));
            check("cmp_done", int'(done), int'(m_done));
        end
    end

    // Running totals of high-pulse cycles and done strobes.
    always @(negedge clk) begin
        if (out_pulse === 1'b1) hi_total++;
        if (done === 1'b1) done_total++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a fresh rising edge on trig; returns just after the start edge.
    task automatic fire(input int ld, input int md);
        load = N'(ld);
        mode = 2'(md);
        trig = 1'b0;
        step();
        trig = 1'b1;
        step();
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            step();
            n++;
        end
        check("idle_timeout", int'(busy), 0);
        step();
    endtask

    initial begin : stim
        int hi0;
        int d0;
        rst = 1'b1; trig = 1'b0; load = '0; mode = 2'd0; enable = 1'b1;
`ifdef TIMER_PRESCALE_EN
        presc = 4'd0;
`endif
        step();
        check_en = 1'b1;
        step();
        check("rst_count", int'(count), 0);
        check("rst_out_pulse", int'(out_pulse), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        rst = 1'b0;
        step();

        // ONESHOT load=4: count 4,3,2,1,0, pulse 4 cycles, done at the fall.
        fire(4, 0);
        hi0 = hi_total; d0 = done_total;
        trig = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("t1_count", int'(count), 4 - i);
            if (i < 4) step();
        end
        check("t1_done_at_fall", int'(done), 1);
        check("t1_out_low", int'(out_pulse), 0);
        step();
        check("t1_done_one_cycle", int'(done), 0);
        check("t1_pulse_len", hi_total - hi0, 4);
        check("t1_done_count", done_total - d0, 1);

        // ONESHOT load=7 with a second edge at cycle 3: ignored.
        fire(7, 0);
        hi0 = hi_total; d0 = done_total;
        trig = 1'b0; step(); step();
        trig = 1'b1; step();
        trig = 1'b0;
        check("t2_count_after_ignored_edge", int'(count), 4);
        wait_idle(40);
        check("t2_pulse_len", hi_total - hi0, 7);
        check("t2_done_count", done_total - d0, 1);

        // RETRIG load=7, re-edge at cycle 5: pulse 12, one done.
        fire(7, 1);
        hi0 = hi_total; d0 = done_total;
        trig = 1'b0;
        repeat (4) step();
        trig = 1'b1; step();
        trig = 1'b0;
        check("t3_reload_count", int'(count), 7);
        wait_idle(40);
        check("t3_pulse_len", hi_total - hi0, 12);
        check("t3_done_count", done_total - d0, 1);

        // RETRIG load=7, re-edge exactly on the expiry cycle: no done, pulse continues.
        fire(7, 1);
        hi0 = hi_total; d0 = done_total;
        trig = 1'b0;
        repeat (6) step();
        check("t3b_count_before_expiry", int'(count), 1);
        trig = 1'b1; step();
        check("t3b_no_done", int'(done), 0);
        check("t3b_busy", int'(busy), 1);
        check("t3b_count_reload", int'(count), 7);
        trig = 1'b0;
        wait_idle(40);
        check("t3b_pulse_len", hi_total - hi0, 14);
        check("t3b_done_count", done_total - d0, 1);

        // PERIODIC load=9 with trig high for 40 cycles: toggles every 9, idle after trig drops.
        fire(9, 2);
        hi0 = hi_total; d0 = done_total;
        for (int i = 1; i < 40; i++) begin
            step();
            if (i == 9) begin
                check("t4_toggle_low", int'(out_pulse), 0);
                check("t4_done_p1", int'(done), 1);
            end
            if (i == 18) check("t4_toggle_high", int'(out_pulse), 1);
        end
        trig = 1'b0;
        wait_idle(60);
        check("t4_high_cycles", hi_total - hi0, 27);
        check("t4_done_count", done_total - d0, 5);

        // enable low for 3 cycles mid-run stretches the pulse by 3.
        fire(6, 0);
        hi0 = hi_total; d0 = done_total;
        trig = 1'b0; step();
        enable = 1'b0;
        repeat (3) step();
        check("t5_count_frozen", int'(count), 5);
        check("t5_out_held", int'(out_pulse), 1);
        enable = 1'b1;
        wait_idle(40);
        check("t5_pulse_len", hi_total - hi0, 9);
        check("t5_done_count", done_total - d0, 1);

        // Reset mid-run: outputs clear at once, no done; a held trig is not an edge.
        fire(10, 0);
        repeat (3) step();
        d0 = done_total;
        rst = 1'b1;
        #1;
        check("t6_rst_count", int'(count), 0);
        check("t6_rst_out", int'(out_pulse), 0);
        check("t6_rst_busy", int'(busy), 0);
        check("t6_rst_done", int'(done), 0);
        step();
        rst = 1'b0;
        load = N'(3);
        repeat (3) step();
        check("t6_held_trig_no_start", int'(busy), 0);
        check("t6_no_done_after_abort", done_total - d0, 0);
        trig = 1'b0; step();
        trig = 1'b1; step();
        check("t6_restart_busy", int'(busy), 1);
        check("t6_restart_count", int'(count), 3);
        trig = 1'b0;
        wait_idle(40);

        // load=0 trigger: no activity.
        hi0 = hi_total; d0 = done_total;
        fire(0, 0);
        repeat (3) step();
        check("t7_busy", int'(busy), 0);
        check("t7_count", int'(count), 0);
        check("t7_no_pulse", hi_total - hi0, 0);
        check("t7_no_done", done_total - d0, 0);
        trig = 1'b0; step();

`ifdef TIMER_PRESCALE_EN
        // presc=2, load=3: pulse 9 cycles.
        presc = 4'd2;
        fire(3, 0);
        hi0 = hi_total; d0 = done_total;
        trig = 1'b0;
        wait_idle(60);
        check("t8_presc_pulse_len", hi_total - hi0, 9);
        check("t8_presc_done", done_total - d0, 1);
        presc = 4'($urandom_range(0, 3));
`endif

        // Randomized run against the model.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 3) == 0) trig = ~trig;
            if ($urandom_range(0, 15) == 0)
                load = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom_range(1, 31));
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            enable = ($urandom_range(0, 9) != 0);
            step();
        end
        rst = 1'b0; enable = 1'b1; trig = 1'b0;
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mode_timer.md
MODE_TIMER -- requirements
Module: mode_timer

Interface
REQ-001 SHALL have parameter N, default 5, giving counter and load width in bits.
REQ-002 SHALL have parameter PS_W, default 4, giving prescaler width in bits; it is used only when TIMER_PRESCALE_EN is defined.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port trig, input, 1 bit: trigger level, synchronous to clk.
REQ-006 SHALL have port load, input, N bits: pulse length or period, in ticks.
REQ-007 SHALL have port mode, input, 2 bits: 00 ONESHOT, 01 RETRIG, 10 PERIODIC, 11 reserved (treated as ONESHOT).
REQ-008 SHALL have port enable, input, 1 bit: when low, count is frozen and starts are ignored.
REQ-009 SHALL have port out_pulse, output, 1 bit: the timer output.
REQ-010 SHALL have port busy, output, 1 bit: high while a run is active.
REQ-011 SHALL have port done, output, 1 bit: one-cycle strobe at each expiry.
REQ-012 SHALL have port count, output, N bits: remaining ticks.

Function
REQ-013 SHALL detect a trigger edge as trig=1 at the current rising clk edge while the registered trig_q=0.
REQ-014 SHALL start a run only from idle, on a trigger edge, with enable=1 and load!=0; at that same clk edge count<=load, busy<=1, out_pulse<=1, and mode is latched into mode_q.
REQ-015 SHALL ignore a trigger edge when load==0: no start, no done strobe.
REQ-016 SHALL decrement count by 1 on every tick while busy and enable=1; the tick is every cycle unless TIMER_PRESCALE_EN is defined.
REQ-017 SHALL expire on a tick with count==1: count<=0 and done<=1 for exactly one cycle; out_pulse stays high for exactly load ticks.
REQ-018 SHALL, in ONESHOT mode, clear busy and out_pulse on expiry and ignore trigger edges while busy.
REQ-019 SHALL, in RETRIG mode, set count<=load on a trigger edge while busy; out_pulse stays high.
REQ-020 SHALL, in RETRIG mode, give a trigger edge on the expiry cycle priority: count reloads, busy stays high, and no done strobe is issued.
REQ-021 SHALL, in PERIODIC mode, on expiry with trig=1 and load!=0, set count<=load (sampled fresh), toggle out_pulse and strobe done.
REQ-022 SHALL, in PERIODIC mode, on expiry with trig=0 or load==0, return to idle with out_pulse=0 and strobe done.
REQ-023 SHALL sample mode and load only at start or reload; changes to either mid-run SHALL have no effect on the current period.
REQ-024 SHALL, with enable=0 mid-run, hold count, out_pulse and busy; trig_q SHALL keep tracking trig.

Reset
REQ-025 SHALL, when rst is asserted, asynchronously clear count, out_pulse, busy, done, trig_q, mode_q and the prescaler to 0.
REQ-026 SHALL, when rst is asserted mid-run, abort the run with no done strobe; after release, trig already high SHALL NOT count as an edge until it goes low then high.

Configuration
REQ-027 SHALL, with TIMER_PRESCALE_EN defined, add input presc[PS_W-1:0] and generate a tick every presc+1 cycles.
REQ-028 SHALL reset the prescaler counter on every start and reload, so the first tick occurs presc+1 cycles after start.
REQ-029 SHALL, with TIMER_PRESCALE_EN undefined, have no presc port, tick=1 every cycle, and no prescaler logic.

Structure
REQ-030 SHALL place the mode encodings (ONESHOT, RETRIG, PERIODIC) and the FSM state type (IDLE, RUN) in package mode_timer_pkg.
REQ-031 SHALL implement the prescaler as sub-module timer_prescaler (inputs clk, rst, clr, presc; output tick), instantiated only under TIMER_PRESCALE_EN.

Verification
REQ-032 SHALL cover: N=5, ONESHOT, load=4, trig rise -> out_pulse high exactly 4 cycles, count 4,3,2,1,0, done one cycle at fall.
REQ-033 SHALL cover: ONESHOT, load=7, second trig edge at cycle 3 -> ignored, pulse still 7 cycles.
REQ-034 SHALL cover: RETRIG, load=7, re-edge at cycle 5 -> pulse totals 12 cycles, one done; re-edge exactly on the expiry cycle -> no done, pulse continues.
REQ-035 SHALL cover: PERIODIC, load=9, trig held high 40 cycles -> out_pulse toggles every 9 cycles with a done each expiry; trig low -> idle at next expiry.
REQ-036 SHALL cover: enable=0 for 3 cycles mid-run -> pulse stretched by 3; rst mid-run -> all outputs 0 immediately, no done; load=0 trigger -> no activity.
REQ-037 SHALL cover, under TIMER_PRESCALE_EN: presc=2, load=3 -> out_pulse high 9 cycles.
